// File: rtl/vp_pkg.sv
// rtl/vp_pkg.sv - shared widths, opcode field bounds and fetch state enum
package vp_pkg;

  localparam int INST_W = 23;
  localparam int PC_W   = 16;
  localparam int OP_HI  = 22;
  localparam int OP_LO  = 18;
  localparam int OP_W   = OP_HI - OP_LO + 1;

  localparam logic [OP_W-1:0] HALT_OPCODE_DEF = 5'b11111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HALT = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - two-entry {inst,pc} FIFO with flush
module fetch_buffer
  import vp_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [INST_W-1:0] push_inst,
  input  logic [PC_W-1:0]   push_pc,
  input  logic              pop,
  input  logic              flush,
  output logic [1:0]        count,
  output logic [INST_W-1:0] head_inst,
  output logic [PC_W-1:0]   head_pc
);

  logic [INST_W-1:0] inst_mem [2];
  logic [PC_W-1:0]   pc_mem   [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count_q;
  logic              do_pop;
  logic              do_push;

  // Guard against popping empty or overfilling; the fetch FSM never asks for either.
  assign do_pop  = pop && (count_q != 2'd0);
  assign do_push = push && ((count_q != 2'd2) || do_pop);

  // Storage, pointers and occupancy; flush discards everything and beats push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_mem[0] <= '0;
      inst_mem[1] <= '0;
      pc_mem[0]   <= '0;
      pc_mem[1]   <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      count_q     <= 2'd0;
    end else if (flush) begin
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      if (do_push) begin
        inst_mem[wr_ptr] <= push_inst;
        pc_mem[wr_ptr]   <= push_pc;
        wr_ptr           <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign count     = count_q;
  assign head_inst = inst_mem[rd_ptr];
  assign head_pc   = pc_mem[rd_ptr];

endmodule

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction fetch FSM with redirect, halt and 2-deep decode buffer
module inst_fetch
  import vp_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC    = 16'h0000,
  parameter logic [OP_W-1:0] HALT_OPCODE = HALT_OPCODE_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              redirect,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] inst,
  output logic [PC_W-1:0]   pc,
  output logic              halted
);

  fetch_state_t      state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic              drop_q, drop_d;
  logic [1:0]        count;
  logic              issue;
  logic              redirect_act;
  logic              buf_push;
  logic              buf_pop;

  // A request goes out only with buffer room and no stale response still in flight.
  assign issue        = (state_q == ST_REQ) && (count < 2'd2) && !drop_q;
  assign redirect_act = redirect && (state_q != ST_IDLE);
  assign buf_push     = (state_q == ST_WAIT) && imem_ack && !redirect_act;
  assign buf_pop      = out_valid && out_ready && !redirect_act;

  assign imem_req  = issue;
  assign imem_addr = issue ? pc_q : '0;
  assign out_valid = (count != 2'd0);
  assign halted    = (state_q == ST_HALT);

  // State, PC and drop-flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
    end
  end

  // Next state: redirect overrides everything; a response still in flight at
  // redirect time (issued this cycle, or awaited in WAIT) is marked for discard.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    drop_d  = drop_q;
    if (redirect_act) begin
      pc_d    = redirect_pc;
      state_d = ST_REQ;
      drop_d  = issue
             || ((state_q == ST_WAIT) && !imem_ack)
             || (drop_q && !imem_ack);
    end else begin
      if (drop_q && imem_ack) begin
        drop_d = 1'b0;
      end
      case (state_q)
        ST_IDLE: begin
          if (redirect) begin
            pc_d = redirect_pc;
          end
          if (start) begin
            state_d = ST_REQ;
          end
        end
        ST_REQ: begin
          if (issue) begin
            state_d = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (imem_ack) begin
            pc_d    = pc_q + 16'd1;
            state_d = (imem_rdata[OP_HI:OP_LO] == HALT_OPCODE) ? ST_HALT : ST_REQ;
          end
        end
        ST_HALT: begin
          state_d = ST_HALT;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  fetch_buffer u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (buf_push),
    .push_inst (imem_rdata),
    .push_pc   (pc_q),
    .pop       (buf_pop),
    .flush     (redirect_act),
    .count     (count),
    .head_inst (inst),
    .head_pc   (pc)
  );

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, SHALL set the PC loaded on reset.
REQ-002 Parameter HALT_OPCODE, default 5'b11111, SHALL set the opcode (inst[22:18]) that stops fetching.
REQ-003 Port clk, input, 1, SHALL be the single clock; all state updates on posedge.
REQ-004 Port rst_n, input, 1, SHALL be the asynchronous active-low reset.
REQ-005 Port start, input, 1, SHALL begin fetching when sampled high in IDLE.
REQ-006 Port imem_req, output, 1, SHALL pulse for one cycle per instruction-memory read.
REQ-007 Port imem_addr, output, 16, SHALL carry the fetch address while imem_req is high.
REQ-008 Port imem_ack, input, 1, SHALL mark imem_rdata valid, one pulse per request, at least 1 cycle after imem_req.
REQ-009 Port imem_rdata, input, 23, SHALL carry the fetched instruction word.
REQ-010 Port redirect, input, 1, SHALL request a PC change (branch/jump).
REQ-011 Port redirect_pc, input, 16, SHALL give the new PC when redirect is high.
REQ-012 Port out_valid, output, 1, SHALL flag inst/pc valid toward decode.
REQ-013 Port out_ready, input, 1, SHALL flag that decode accepts this cycle.
REQ-014 Port inst, output, 23, SHALL carry the instruction at buffer head.
REQ-015 Port pc, output, 16, SHALL carry the address of inst.
REQ-016 Port halted, output, 1, SHALL be high while in HALT.

Function
REQ-017 FSM SHALL have states IDLE, REQ, WAIT, HALT.
REQ-018 IDLE: start high -> REQ; no requests issued.
REQ-019 REQ: when buffer count < 2, imem_req=1 and imem_addr=pc_reg, then -> WAIT next cycle; when count = 2, remain in REQ without issuing.
REQ-020 WAIT: on imem_ack push {imem_rdata, pc_reg} into buffer, pc_reg <= pc_reg+1; -> HALT if imem_rdata[22:18]==HALT_OPCODE, else -> REQ.
REQ-021 At most one request SHALL be outstanding; the count<2 issue rule guarantees the push fits.
REQ-022 pc_reg SHALL wrap 16'hFFFF -> 16'h0000.
REQ-023 out_valid = (count != 0); pop on out_valid & out_ready; push and pop in the same cycle leave count unchanged and preserve order.
REQ-024 inst/pc SHALL hold stable while out_valid & !out_ready.
REQ-025 redirect (any state except IDLE) SHALL, same edge: pc_reg <= redirect_pc, flush buffer (count=0), go to REQ; an outstanding request's later imem_ack SHALL be discarded (drop flag), and the next request waits until that ack arrives.
REQ-026 redirect in IDLE SHALL only load pc_reg.
REQ-027 redirect coinciding with imem_ack SHALL discard that response; redirect wins over pop.
REQ-028 HALT: no requests; buffered entries still drain; exit only via redirect or reset.
REQ-029 imem_ack with nothing outstanding SHALL be ignored.

Reset
REQ-030 rst_n low SHALL asynchronously force state=IDLE, pc_reg=RESET_PC, count=0, drop flag=0, imem_req=0, imem_addr=0, out_valid=0, inst=0, pc=0, halted=0.
REQ-031 Reset mid-transaction SHALL abandon the outstanding request; a later stray imem_ack is ignored per REQ-029.

Structure
REQ-032 Package vp_pkg SHALL hold INST_W=23, PC_W=16, opcode field bounds [22:18], HALT_OPCODE default, and the fetch state enum.
REQ-033 Sub-module fetch_buffer SHALL implement the 2-entry {inst,pc} FIFO with push, pop, flush, count.

Verification
REQ-034 Reset, start, imem_ack 2 cycles after each req, out_ready=1 -> imem_addr 0,1,2; decode sees pc 0,1,2 with matching inst.
REQ-035 out_ready=0 for 10 cycles -> exactly 2 entries buffered, no third imem_req; release -> pops in order, fetching resumes.
REQ-036 redirect to 16'h0040 while WAIT -> pending ack dropped, buffer empty, next imem_addr=16'h0040 after that ack.
REQ-037 Fetch at 16'hFFFF -> next imem_addr 16'h0000.
REQ-038 imem_rdata opcode 5'b11111 at pc 5 -> halted=1, no further imem_req, pc 5 still delivered; redirect to 16'h0010 -> fetch resumes at 16'h0010.
REQ-039 rst_n asserted mid-WAIT -> all outputs at reset values immediately; stray imem_ack ignored.
